// File: rtl/montar_pin_pkg.sv
// Shared types for the keypad -> PIN verifier link.
// Holds the pinPac_t bundle, key codes and the collector state enum.
package montar_pin_pkg;

   typedef struct packed {
      logic       status;
      logic [3:0] digit1;
      logic [3:0] digit2;
      logic [3:0] digit3;
      logic [3:0] digit4;
   } pinPac_t;

   localparam logic [3:0] KEY_BACK    = 4'hA;
   localparam logic [3:0] KEY_ENTER   = 4'hB;
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   typedef enum logic [1:0] {
      COLLECT,
      SEND,
      WAIT_RESULT,
      FLUSH
   } pin_state_t;

   function automatic logic is_digit(input logic [3:0] c);
      return (c <= 4'd9);
   endfunction

endpackage

// File: rtl/montar_pin_timer.sv
// Inactivity timer for the PIN collector.
// Clear wins over enable; expire is a one-cycle flag at count TIMEOUT_CYCLES-1.
module pin_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          w_hit;

   assign w_hit    = (r_cnt == LAST);
   assign o_expire = i_en & ~i_clr & w_hit;

   // Idle counter: reload on clear, wrap after the expiry cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/montar_pin.sv
// Keypad PIN assembler: collects 4 digits, submits a pinPac_t, waits for result.
// Optional AUTO_SUBMIT_EN: 4th digit submits directly, KEY_ENTER is ignored.
module montar_pin
   import montar_pin_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int HOLD_CYCLES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       result_valid,
   output pinPac_t    pin_out,
   output logic [2:0] digit_count,
   output logic       busy,
   output logic       entry_error
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   pin_state_t    r_state;
   logic [3:0]    r_dig [4];
   logic [2:0]    r_cnt;
   logic [HW-1:0] r_hold;
   logic          r_status;
   logic          r_busy;
   logic          r_err;

   logic       w_key;
   logic       w_dig;
   logic       w_back;
   logic       w_enter;
   logic       w_accept;
   logic       w_clr;
   logic       w_en;
   logic       w_expire;
   logic [1:0] w_slot;
   logic [1:0] w_last;

   assign w_key  = key_valid & (r_state == COLLECT);
   assign w_dig  = w_key & is_digit(key_code);
   assign w_back = w_key & (key_code == KEY_BACK);
`ifdef AUTO_SUBMIT_EN
   assign w_enter = 1'b0;
`else
   assign w_enter = w_key & (key_code == KEY_ENTER);
`endif
   assign w_accept = w_dig | w_back | w_enter;
   assign w_clr    = w_accept | (r_state == FLUSH);
   assign w_en     = ((r_state == COLLECT) & (r_cnt != 3'd0))
                   | (r_state == WAIT_RESULT);
   assign w_slot   = r_cnt[1:0];
   assign w_last   = r_cnt[1:0] - 2'd1;

   pin_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .o_expire(w_expire)
   );

   assign pin_out     = {r_status, r_dig[0], r_dig[1], r_dig[2], r_dig[3]};
   assign digit_count = r_cnt;
   assign busy        = r_busy;
   assign entry_error = r_err;

   // Collector FSM with registered status/busy/error and digit slots.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= COLLECT;
         r_cnt    <= 3'd0;
         r_hold   <= '0;
         r_status <= 1'b0;
         r_busy   <= 1'b0;
         r_err    <= 1'b0;
         for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
      end else begin
         r_err <= 1'b0;
         unique case (r_state)
            COLLECT: begin
               if (w_dig) begin
                  if (r_cnt != 3'd4) begin
                     r_dig[w_slot] <= key_code;
                     r_cnt         <= r_cnt + 3'd1;
`ifdef AUTO_SUBMIT_EN
                     if (r_cnt == 3'd3) begin
                        r_state  <= SEND;
                        r_status <= 1'b1;
                        r_busy   <= 1'b1;
                        r_hold   <= '0;
                     end
`endif
                  end
               end else if (w_back) begin
                  if (r_cnt != 3'd0) begin
                     r_dig[w_last] <= DIGIT_BLANK;
                     r_cnt         <= r_cnt - 3'd1;
                  end
               end else if (w_enter) begin
                  if (r_cnt == 3'd4) begin
                     r_state  <= SEND;
                     r_status <= 1'b1;
                     r_busy   <= 1'b1;
                     r_hold   <= '0;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= FLUSH;
                  end
               end else if (w_expire) begin
                  r_err   <= 1'b1;
                  r_state <= FLUSH;
               end
            end
            SEND: begin
               if (r_hold == HOLD_LAST) begin
                  r_status <= 1'b0;
                  r_state  <= WAIT_RESULT;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            WAIT_RESULT: begin
               if (result_valid) begin
                  r_busy  <= 1'b0;
                  r_state <= FLUSH;
               end else if (w_expire) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= FLUSH;
               end
            end
            FLUSH: begin
               r_cnt   <= 3'd0;
               r_state <= COLLECT;
               for (int i = 0; i < 4; i++) r_dig[i] <= DIGIT_BLANK;
            end
            default: r_state <= FLUSH;
         endcase
      end
   end

endmodule

// File: tb/tb_montar_pin.sv
// Self-checking bench for montar_pin.
// Submissions are scored against a queue of expected pinPac_t words.
module tb_montar_pin;
   import montar_pin_pkg::*;

   localparam int T = 5000;
   localparam int H = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'hC;
   logic       result_valid = 1'b0;
   pinPac_t    pin_out;
   logic [2:0] digit_count;
   logic       busy;
   logic       entry_error;

   int n_chk = 0;
   int n_err = 0;
   logic [16:0] q_exp [$];
   logic        prev_status = 1'b0;

   always #5 clk = ~clk;

   montar_pin #(
      .TIMEOUT_CYCLES(T),
      .HOLD_CYCLES   (H)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .result_valid(result_valid),
      .pin_out     (pin_out),
      .digit_count (digit_count),
      .busy        (busy),
      .entry_error (entry_error)
   );

   // Scoreboard: every rising status must match the next queued submission.
   always @(negedge clk) begin
      if (pin_out.status === 1'b1 && prev_status !== 1'b1) begin
         n_chk++;
         if (q_exp.size() == 0) begin
            n_err++;
            $display("FAIL sb_spurious: got %h with no submission queued", pin_out);
         end else begin
            logic [16:0] e;
            e = q_exp.pop_front();
            if (pin_out !== e) begin
               n_err++;
               $display("FAIL sb_pin: got %h want %h", pin_out, e);
            end
         end
      end
      prev_status <= pin_out.status;
   end

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'hC;
   endtask

   task automatic pulse_result();
      result_valid = 1'b1;
      @(negedge clk);
      result_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if (pin_out !== 17'h0FFFF) begin
         n_err++; $display("FAIL reset_pin: got %h want 0ffff", pin_out);
      end
      n_chk++;
      if (digit_count !== 3'd0) begin
         n_err++; $display("FAIL reset_count: got %0d want 0", digit_count);
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_chk++;
      if (entry_error !== 1'b0) begin
         n_err++; $display("FAIL reset_err: got %b want 0", entry_error);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_send();
      q_exp.push_back(17'h11234);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      press(KEY_ENTER);
      n_chk++;
      if (pin_out.status !== 1'b1) begin
         n_err++; $display("FAIL rms_status: got %b want 1", pin_out.status);
      end
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if (pin_out !== 17'h0FFFF) begin
         n_err++; $display("FAIL rms_pin: got %h want 0ffff", pin_out);
      end
      n_chk++;
      if (digit_count !== 3'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL rms_cnt_busy: got %0d/%b want 0/0", digit_count, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_submit();
      q_exp.push_back(17'h11234);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      press(KEY_ENTER);
      n_chk++;
      if (pin_out.status !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL sub_rise: got %b/%b want 1/1", pin_out.status, busy);
      end
      @(negedge clk);
      n_chk++;
      if (pin_out.status !== 1'b1) begin
         n_err++; $display("FAIL sub_hold2: got %b want 1", pin_out.status);
      end
      @(negedge clk);
      n_chk++;
      if (pin_out !== 17'h01234 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL sub_fall: got %h/%b want 01234/1", pin_out, busy);
      end
      repeat (3) @(negedge clk);
      pulse_result();
      n_chk++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL sub_busy_drop: got %b want 0", busy);
      end
      @(negedge clk);
      n_chk++;
      if (pin_out !== 17'h0FFFF || digit_count !== 3'd0) begin
         n_err++;
         $display("FAIL sub_flush: got %h/%0d want 0ffff/0", pin_out, digit_count);
      end
   endtask

   task automatic test_backspace();
      press(4'd7); press(4'd8); press(KEY_BACK); press(4'd9);
      n_chk++;
      if (pin_out !== 17'h079FF || digit_count !== 3'd2) begin
         n_err++;
         $display("FAIL bs_digits: got %h/%0d want 079ff/2", pin_out, digit_count);
      end
      press(KEY_ENTER);
      n_chk++;
      if (entry_error !== 1'b1 || pin_out.status !== 1'b0) begin
         n_err++;
         $display("FAIL bs_short_enter: got err %b st %b want 1/0",
                  entry_error, pin_out.status);
      end
      @(negedge clk);
      n_chk++;
      if (entry_error !== 1'b0 || digit_count !== 3'd0 || pin_out !== 17'h0FFFF) begin
         n_err++;
         $display("FAIL bs_after: got err %b cnt %0d pin %h want 0/0/0ffff",
                  entry_error, digit_count, pin_out);
      end
   endtask

   task automatic test_timeout();
      int n;
      press(4'd5); press(4'd6);
      n = 0;
      while (entry_error !== 1'b1 && n < T + 20) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n != T) begin
         n_err++; $display("FAIL to_latency: got %0d cycles want %0d", n, T);
      end
      @(negedge clk);
      n_chk++;
      if (digit_count !== 3'd0 || entry_error !== 1'b0) begin
         n_err++;
         $display("FAIL to_flush: got cnt %0d err %b want 0/0", digit_count, entry_error);
      end
   endtask

   task automatic test_expiry_key();
      int seen;
      press(4'd5); press(4'd6);
      repeat (T - 2) @(negedge clk);
      press(4'd1);
      n_chk++;
      if (entry_error !== 1'b0 || digit_count !== 3'd3) begin
         n_err++;
         $display("FAIL ek_win: got err %b cnt %0d want 0/3", entry_error, digit_count);
      end
      n_chk++;
      if (pin_out !== 17'h0561F) begin
         n_err++; $display("FAIL ek_digits: got %h want 0561f", pin_out);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (entry_error === 1'b1) seen++;
      end
      n_chk++;
      if (seen != 0) begin
         n_err++; $display("FAIL ek_quiet: got %0d error pulses want 0", seen);
      end
      press(KEY_ENTER);
      n_chk++;
      if (entry_error !== 1'b1) begin
         n_err++; $display("FAIL ek_cleanup: got %b want 1", entry_error);
      end
      @(negedge clk);
   endtask

   task automatic test_busy();
      int n;
      q_exp.push_back(17'h11234);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      press(KEY_ENTER);
      n = 0;
      while (n < T + 30) begin
         @(negedge clk);
         n++;
         if (entry_error === 1'b1) break;
         if (n == 1) begin
            n_chk++;
            if (pin_out.status !== 1'b1) begin
               n_err++; $display("FAIL busy_hold: got %b want 1", pin_out.status);
            end
         end
         if (n == 2) begin
            n_chk++;
            if (pin_out.status !== 1'b0 || busy !== 1'b1) begin
               n_err++;
               $display("FAIL busy_wait: got %b/%b want 0/1", pin_out.status, busy);
            end
         end
         if (n == 6) begin
            n_chk++;
            if (pin_out[15:0] !== 16'h1234 || digit_count !== 3'd4) begin
               n_err++;
               $display("FAIL busy_keys: got %h/%0d want 1234/4",
                        pin_out[15:0], digit_count);
            end
         end
         key_valid = (n >= 3 && n <= 5);
         key_code  = key_valid ? 4'd9 : 4'hC;
      end
      key_valid = 1'b0;
      n_chk++;
      if (n != T + 2) begin
         n_err++; $display("FAIL busy_timeout: got %0d cycles want %0d", n, T + 2);
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || digit_count !== 3'd0 || pin_out !== 17'h0FFFF) begin
         n_err++;
         $display("FAIL busy_flush: got %b/%0d/%h want 0/0/0ffff",
                  busy, digit_count, pin_out);
      end
   endtask

   task automatic test_back_to_back();
      q_exp.push_back(17'h19876);
      press(4'd9); press(4'd8); press(4'd7); press(4'd6);
      press(KEY_ENTER);
      pulse_result();
      n_chk++;
      if (pin_out.status !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_send_ignore: got %b/%b want 1/1", pin_out.status, busy);
      end
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || pin_out !== 17'h09876) begin
         n_err++;
         $display("FAIL b2b_wait: got %b/%h want 1/09876", busy, pin_out);
      end
      pulse_result();
      @(negedge clk);
      q_exp.push_back(17'h10000);
      press(4'd0); press(4'd0); press(4'd0); press(4'd0);
      press(KEY_ENTER);
      n_chk++;
      if (pin_out.status !== 1'b1) begin
         n_err++; $display("FAIL b2b_second: got %b want 1", pin_out.status);
      end
      repeat (2) @(negedge clk);
      pulse_result();
      @(negedge clk);
      n_chk++;
      if (digit_count !== 3'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_end: got %0d/%b want 0/0", digit_count, busy);
      end
   endtask

   task automatic test_auto();
      q_exp.push_back(17'h14321);
      press(4'd4); press(4'd3); press(4'd2);
      n_chk++;
      if (pin_out.status !== 1'b0) begin
         n_err++; $display("FAIL auto_early: got %b want 0", pin_out.status);
      end
      press(4'd1);
      n_chk++;
      if (pin_out.status !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL auto_rise: got %b/%b want 1/1", pin_out.status, busy);
      end
      press(4'd9);
      @(negedge clk);
      n_chk++;
      if (pin_out !== 17'h04321 || digit_count !== 3'd4) begin
         n_err++;
         $display("FAIL auto_5th: got %h/%0d want 04321/4", pin_out, digit_count);
      end
      pulse_result();
      @(negedge clk);
      n_chk++;
      if (pin_out !== 17'h0FFFF || digit_count !== 3'd0) begin
         n_err++;
         $display("FAIL auto_flush: got %h/%0d want 0ffff/0", pin_out, digit_count);
      end
   endtask

   initial begin
      test_reset();
`ifdef AUTO_SUBMIT_EN
      test_timeout();
      test_auto();
`else
      test_reset_mid_send();
      test_submit();
      test_backspace();
      test_timeout();
      test_expiry_key();
      test_busy();
      test_back_to_back();
`endif
      repeat (2) @(negedge clk);
      n_chk++;
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d pending want 0", q_exp.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
